// File: rtl/syzygy_adc_emu_tx.sv
// LTC2268-14 2-lane/16-bit ADC transmit emulator for SYZYGY loopback: training burst, then buffered samples.
// Define ADC_EMU_RAMP_EN to make the underflow filler a 14-bit ramp instead of the last sent sample.
module syzygy_adc_emu_tx #(
  parameter int unsigned TRAIN_CYCLES  = 64,
  parameter logic [13:0] TRAIN_PATTERN = 14'h2A5B
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [13:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  lane0_word,
  output logic [7:0]  lane1_word,
  output logic [7:0]  frame_word,
  output logic [7:0]  dco_word,
  output logic        train_active,
  output logic        running,
  output logic [15:0] underflow_count
);

  typedef enum logic [1:0] {IDLE, TRAIN, RUN} state_t;

  state_t      state, nxt;
  logic [15:0] tcnt;
  logic [13:0] buf0, buf1;
  logic [1:0]  occ, occ_pop, occ_nxt;
  logic        push, pop, underflow;
  logic [13:0] filler, sample_nxt;
  logic [15:0] w16;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (enable) nxt = TRAIN;
      TRAIN:   if (!enable) nxt = IDLE;
               else if (tcnt == 16'(TRAIN_CYCLES - 1)) nxt = RUN;
      RUN:     if (!enable) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Pop decisions use occupancy before this edge's push, giving one cycle of buffer latency.
  always_comb begin
    pop       = (nxt == RUN) && (occ != 2'd0);
    underflow = (nxt == RUN) && (occ == 2'd0);
    push      = s_valid && s_ready && (nxt != IDLE);
    occ_pop   = occ - {1'b0, pop};
    occ_nxt   = (nxt == IDLE) ? 2'd0 : occ_pop + {1'b0, push};
    sample_nxt = '0;
    case (nxt)
      TRAIN:   sample_nxt = TRAIN_PATTERN;
      RUN:     sample_nxt = pop ? buf0 : filler;
      default: sample_nxt = '0;
    endcase
    w16 = {sample_nxt, 2'b00};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt <= '0;
      occ  <= '0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      tcnt <= (state == TRAIN && nxt == TRAIN) ? tcnt + 16'd1 : '0;
      occ  <= occ_nxt;
      if (pop) buf0 <= buf1;
      if (push) begin
        if (occ_pop == 2'd0) buf0 <= s_data;
        else                 buf1 <= s_data;
      end
    end
  end

`ifdef ADC_EMU_RAMP_EN
  logic [13:0] ramp;
  assign filler = ramp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        ramp <= '0;
    else if (state != TRAIN && nxt == TRAIN) ramp <= '0;
    else if (underflow)                  ramp <= ramp + 14'd1;
  end
`else
  logic [13:0] last;
  assign filler = last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          last <= '0;
    else if (nxt != IDLE)  last <= sample_nxt;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane0_word      <= '0;
      lane1_word      <= '0;
      frame_word      <= '0;
      dco_word        <= '0;
      s_ready         <= 1'b0;
      train_active    <= 1'b0;
      running         <= 1'b0;
      underflow_count <= '0;
    end else begin
      lane1_word   <= w16[15:8];
      lane0_word   <= w16[7:0];
      frame_word   <= (nxt != IDLE) ? 8'hF0 : 8'h00;
      dco_word     <= (nxt != IDLE) ? 8'hAA : 8'h00;
      s_ready      <= (nxt != IDLE) && (occ_nxt != 2'd2);
      train_active <= (nxt == TRAIN);
      running      <= (nxt == RUN);
      if (underflow && underflow_count != 16'hFFFF)
        underflow_count <= underflow_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_syzygy_adc_emu_tx.sv
// Scoreboard bench for syzygy_adc_emu_tx (TRAIN_CYCLES=4); expected words queued per active cycle.
module tb_syzygy_adc_emu_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [13:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  lane0_word, lane1_word, frame_word, dco_word;
  logic        train_active, running;
  logic [15:0] underflow_count;

  syzygy_adc_emu_tx #(.TRAIN_CYCLES(4), .TRAIN_PATTERN(14'h2A5B)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .lane0_word(lane0_word), .lane1_word(lane1_word),
    .frame_word(frame_word), .dco_word(dco_word), .train_active(train_active),
    .running(running), .underflow_count(underflow_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        tr;
    logic        rn;
    logic [7:0]  l1;
    logic [7:0]  l0;
    logic [15:0] uf;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   ramp_mode;

  initial begin
`ifdef ADC_EMU_RAMP_EN
    ramp_mode = 1'b1;
`else
    ramp_mode = 1'b0;
`endif
  end

  function automatic logic [13:0] fill(input logic [13:0] last_s, input logic [13:0] ramp_s);
    return ramp_mode ? ramp_s : last_s;
  endfunction

  task automatic expect_word(input logic is_train, input logic [13:0] smp, input logic [15:0] uf);
    exp_t e;
    logic [15:0] w;
    w = {smp, 2'b00};
    e.tr = is_train;
    e.rn = !is_train;
    e.l1 = w[15:8];
    e.l0 = w[7:0];
    e.uf = uf;
    exp_q.push_back(e);
  endtask

  task automatic expect_train(input logic [15:0] uf);
    for (int unsigned i = 0; i < 4; i++) expect_word(1'b1, 14'h2A5B, uf);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string name, input logic [15:0] uf);
    check({name, "_words"}, {lane1_word, lane0_word, frame_word, dco_word}, 32'h0);
    check({name, "_flags"}, {s_ready, train_active, running}, 3'b000);
    check({name, "_uf"}, underflow_count, uf);
  endtask

  // Monitor: every cycle the DUT is in TRAIN or RUN it presents a word set to score.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (train_active || running) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got l1=%0h l0=%0h tr=%0b rn=%0b, none expected",
                 lane1_word, lane0_word, train_active, running);
      end else begin
        e = exp_q.pop_front();
        check("cycle_words",
              {train_active, running, lane1_word, lane0_word, frame_word, dco_word, underflow_count},
              {e.tr, e.rn, e.l1, e.l0, 8'hF0, 8'hAA, e.uf});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    check_idle("reset", 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("idle_after_reset", 16'd0);

    // Training with no input, underflow filler, then a back-to-back stream
    expect_train(16'd0);
    expect_word(1'b0, fill(14'h2A5B, 14'd0), 16'd1);
    expect_word(1'b0, fill(14'h2A5B, 14'd1), 16'd2);
    expect_word(1'b0, fill(14'h2A5B, 14'd2), 16'd3);
    expect_word(1'b0, fill(14'h2A5B, 14'd3), 16'd4);
    expect_word(1'b0, 14'h3FFF, 16'd4);
    expect_word(1'b0, 14'h0001, 16'd4);
    expect_word(1'b0, 14'h1234, 16'd4);
    expect_word(1'b0, fill(14'h1234, 14'd4), 16'd5);
    enable = 1'b1;
    repeat (7) @(negedge clk);
    check("run_ready", s_ready, 1'b1);
    s_valid = 1'b1;
    s_data  = 14'h3FFF;
    @(negedge clk); s_data = 14'h0001;
    @(negedge clk); s_data = 14'h1234;
    @(negedge clk); s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    check_idle("disable_b", 16'd5);

    // Prefill during training, then disable with one entry buffered
    expect_train(16'd5);
    expect_word(1'b0, 14'h0155, 16'd5);
    expect_word(1'b0, 14'h2AAA, 16'd5);
    enable  = 1'b1;
    s_valid = 1'b1;
    s_data  = 14'h0155;
    @(negedge clk);
    @(negedge clk); s_data = 14'h2AAA;
    @(negedge clk);
    check("full_ready", s_ready, 1'b0);
    s_data = 14'h1111;
    @(negedge clk);
    check("full_ready_hold", s_ready, 1'b0);
    @(negedge clk);
    check("ready_after_pop", s_ready, 1'b1);
    @(negedge clk);
    enable  = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check_idle("disable_c", 16'd5);

    // Re-enable: buffered 1111 must never appear
    expect_train(16'd5);
    expect_word(1'b0, fill(14'h2A5B, 14'd0), 16'd6);
    expect_word(1'b0, fill(14'h2A5B, 14'd1), 16'd7);
    enable = 1'b1;
    repeat (6) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check_idle("disable_reenable", 16'd7);

    // Asynchronous reset mid-RUN with a buffered entry
    expect_train(16'd7);
    expect_word(1'b0, 14'h0AAA, 16'd7);
    enable  = 1'b1;
    s_valid = 1'b1;
    s_data  = 14'h0AAA;
    @(negedge clk);
    @(negedge clk); s_data = 14'h1555;
    @(negedge clk); s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_running", running, 1'b1);
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    check_idle("async_reset", 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Buffer was flushed by reset: first RUN word is filler, not 1555
    expect_train(16'd0);
    expect_word(1'b0, fill(14'h2A5B, 14'd0), 16'd1);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check_idle("post_reset_run", 16'd1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
